// File: rtl/ahb_slave_mem.sv
// ============================================================================
// ahb_slave_mem
// ----------------------------------------------------------------------------
// AHB-Lite responder backed by a word-organised memory of DEPTH 32-bit words.
// It completes single beats issued by the team's ahb_master: every accepted
// NONSEQ/SEQ beat is handled on its own (hburst is ignored). OKAY data phases
// may be stretched by WAIT_STATES hreadyout-low cycles. Out-of-range,
// misaligned and oversize accesses get the two-cycle ERROR response and
// never touch memory.
//
// Ports
//   hclk       bus clock, rising edge
//   hresetn    asynchronous active-low reset
//   hsel       slave select from the bus decoder
//   haddr      byte address (address phase)
//   hwrite     1 = write, 0 = read (address phase)
//   hsize      0 = byte, 1 = halfword, 2 = word (address phase)
//   hburst     burst type, accepted and ignored
//   htrans     IDLE / BUSY / NONSEQ / SEQ
//   hready     bus-level ready (previous data phase complete)
//   hwdata     write data (data phase)
//   hreadyout  slave ready for the current data phase
//   hresp      0 = OKAY, 1 = ERROR
//   hrdata     read data, valid while hreadyout = 1 in a read data phase
// ============================================================================
module ahb_slave_mem #(
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic [1:0]  htrans,
   input  logic        hready,
   input  logic [31:0] hwdata,
   output logic        hreadyout,
   output logic        hresp,
   output logic [31:0] hrdata
);

   localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);
   localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t        state;
   state_t        next_state;
   state_t        accept_state;

   logic [31:0]   mem [DEPTH];

   logic [AW+1:0] addr_q;
   logic          write_q;
   logic [1:0]    size_q;
   logic [3:0]    wait_cnt;
   logic [31:0]   hrdata_q;

   logic          accept_now;
   logic          addr_err;
   logic [3:0]    lane_en;
   logic          commit;
   logic [AW-1:0] rd_idx;
   logic [31:0]   rd_word;
   logic          entering_read;
   logic          load_rdata;

   logic          unused_hburst;

   // Every beat stands alone, so the burst type carries no information here.
   assign unused_hburst = ^hburst;

   // hreadyout and hresp are a pure function of the state: low ready only in
   // the stretch cycles (WAIT) and the first ERROR cycle.
   assign hreadyout = (state != ST_WAIT) && (state != ST_ERR1);
   assign hresp     = (state == ST_ERR1) || (state == ST_ERR2);
   assign hrdata    = hrdata_q;

   // A beat is taken only at an edge where this slave's own data phase is
   // closing too; gating with hreadyout keeps WAIT/ERR1 from ever accepting.
   assign accept_now = hsel && hready && htrans[1] && hreadyout;

   // Address-phase legality check, evaluated on the live bus signals.
   always_comb begin
      addr_err = 1'b0;
      if (haddr >= ADDR_LIMIT) begin
         addr_err = 1'b1;
      end
      if (hsize > 3'd2) begin
         addr_err = 1'b1;
      end
      if ((hsize == 3'd1) && haddr[0]) begin
         addr_err = 1'b1;
      end
      if ((hsize == 3'd2) && (haddr[1:0] != 2'b00)) begin
         addr_err = 1'b1;
      end
   end

   // Where a freshly accepted beat goes: error path, stretched path or
   // straight to the access cycle.
   always_comb begin
      accept_state = ST_ACCESS;
      if (addr_err) begin
         accept_state = ST_ERR1;
      end else if (WAIT_STATES > 0) begin
         accept_state = ST_WAIT;
      end
   end

   // Next-state logic. IDLE, ACCESS and ERR2 all present hreadyout = 1, so
   // each of them can pick up a pipelined beat at its closing edge.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (accept_now) begin
               next_state = accept_state;
            end
         end
         ST_WAIT: begin
            if (wait_cnt == 4'd0) begin
               next_state = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (accept_now) begin
               next_state = accept_state;
            end else begin
               next_state = ST_IDLE;
            end
         end
         ST_ERR1: begin
            next_state = ST_ERR2;
         end
         ST_ERR2: begin
            if (accept_now) begin
               next_state = accept_state;
            end else begin
               next_state = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Little-endian byte lanes of the registered beat. Only legal sizes reach
   // ACCESS, so size_q never holds an oversize code when this is used.
   always_comb begin
      lane_en = 4'b0000;
      case (size_q)
         2'd0:    lane_en[addr_q[1:0]] = 1'b1;
         2'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
         default: lane_en = 4'b1111;
      endcase
   end

   assign commit = (state == ST_ACCESS) && write_q;

   // Read fetch for the beat entering ACCESS at the coming edge. From WAIT
   // the address is already registered; otherwise it is the beat being
   // accepted right now. A write committing at that same edge is merged in
   // lane by lane so the read never sees stale data.
   always_comb begin
      rd_idx  = (state == ST_WAIT) ? addr_q[AW+1:2] : haddr[AW+1:2];
      rd_word = mem[rd_idx];
      if (commit && (addr_q[AW+1:2] == rd_idx)) begin
         for (int k = 0; k < 4; k++) begin
            if (lane_en[k]) begin
               rd_word[8*k +: 8] = hwdata[8*k +: 8];
            end
         end
      end
   end

   assign entering_read = (state == ST_WAIT) ? !write_q : !hwrite;
   assign load_rdata    = (next_state == ST_ACCESS) && entering_read;

   // Control registers. Reset drops any beat in flight, so a write caught in
   // WAIT never reaches ACCESS and never commits.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state    <= ST_IDLE;
         addr_q   <= '0;
         write_q  <= 1'b0;
         size_q   <= 2'd0;
         wait_cnt <= 4'd0;
         hrdata_q <= 32'd0;
      end else begin
         state <= next_state;
         if (accept_now) begin
            addr_q  <= haddr[AW+1:0];
            write_q <= hwrite;
            size_q  <= hsize[1:0];
         end
         if (accept_now && (accept_state == ST_WAIT)) begin
            wait_cnt <= WAIT_LOAD;
         end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         if (load_rdata) begin
            hrdata_q <= rd_word;
         end
      end
   end

   // Memory array: no reset, contents survive hresetn. Writes land at the
   // edge that closes the ACCESS cycle, using the data-phase hwdata.
   always_ff @(posedge hclk) begin
      if (commit) begin
         for (int k = 0; k < 4; k++) begin
            if (lane_en[k]) begin
               mem[addr_q[AW+1:2]][8*k +: 8] <= hwdata[8*k +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// ============================================================================
// tb_ahb_slave_mem
// ----------------------------------------------------------------------------
// Bench for ahb_slave_mem. Three instances run with WAIT_STATES = 0, 2 and 3
// (DEPTH = 256), each driven by its own pipelined master model. A word-array
// reference memory predicts read data, wait counts and ERROR responses.
// ============================================================================
module tb_ahb_slave_mem;

   localparam int NI          = 3;
   localparam int CYCLE_LIMIT = 4000;
   localparam int WS [NI]     = '{0, 2, 3};

   typedef struct packed {
      logic        filler;
      logic        sel;
      logic [1:0]  trans;
      logic        write;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } xfer_t;

   logic        hclk;
   logic        hresetn;
   logic        hsel_a      [NI];
   logic [31:0] haddr_a     [NI];
   logic        hwrite_a    [NI];
   logic [2:0]  hsize_a     [NI];
   logic [2:0]  hburst_a    [NI];
   logic [1:0]  htrans_a    [NI];
   logic [31:0] hwdata_a    [NI];
   logic        hreadyout_a [NI];
   logic        hresp_a     [NI];
   logic [31:0] hrdata_a    [NI];

   logic [31:0] mem_m   [NI][256];
   logic [31:0] last_rd [NI];
   xfer_t       seq_q   [$];

   int tests_run;
   int tests_failed;

   ahb_slave_mem #(.DEPTH(256), .WAIT_STATES(0)) u_ws0 (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel_a[0]), .haddr(haddr_a[0]),
      .hwrite(hwrite_a[0]), .hsize(hsize_a[0]), .hburst(hburst_a[0]),
      .htrans(htrans_a[0]), .hready(hreadyout_a[0]), .hwdata(hwdata_a[0]),
      .hreadyout(hreadyout_a[0]), .hresp(hresp_a[0]), .hrdata(hrdata_a[0]));

   ahb_slave_mem #(.DEPTH(256), .WAIT_STATES(2)) u_ws2 (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel_a[1]), .haddr(haddr_a[1]),
      .hwrite(hwrite_a[1]), .hsize(hsize_a[1]), .hburst(hburst_a[1]),
      .htrans(htrans_a[1]), .hready(hreadyout_a[1]), .hwdata(hwdata_a[1]),
      .hreadyout(hreadyout_a[1]), .hresp(hresp_a[1]), .hrdata(hrdata_a[1]));

   ahb_slave_mem #(.DEPTH(256), .WAIT_STATES(3)) u_ws3 (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel_a[2]), .haddr(haddr_a[2]),
      .hwrite(hwrite_a[2]), .hsize(hsize_a[2]), .hburst(hburst_a[2]),
      .htrans(htrans_a[2]), .hready(hreadyout_a[2]), .hwdata(hwdata_a[2]),
      .hreadyout(hreadyout_a[2]), .hresp(hresp_a[2]), .hrdata(hrdata_a[2]));

   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   // One comparison: counts it, and on mismatch counts and reports it.
   task automatic checkOutput(input int k, input string tag,
                              input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s[ws%0d] observed=%h expected=%h", tag, WS[k], observed, expected);
      end
   endtask

   function automatic xfer_t mk(input logic wr, input logic [31:0] a,
                                input logic [2:0] sz, input logic [31:0] wd);
      xfer_t x;
      x.filler = 1'b0;
      x.sel    = 1'b1;
      x.trans  = 2'b10;
      x.write  = wr;
      x.addr   = a;
      x.size   = sz;
      x.wdata  = wd;
      return x;
   endfunction

   function automatic xfer_t idle_x();
      xfer_t x;
      x = mk(1'b0, 32'd0, 3'd0, 32'd0);
      x.sel   = 1'b0;
      x.trans = 2'b00;
      return x;
   endfunction

   // Reference rules for an illegal beat.
   function automatic logic model_err(input logic [31:0] a, input logic [2:0] sz);
      return (a >= 32'd1024) || (sz > 3'd2) || ((sz == 3'd1) && a[0]) ||
             ((sz == 3'd2) && (a[1:0] != 2'b00));
   endfunction

   // Reference byte-lane write into the model memory.
   function automatic void model_write(input int k, input logic [31:0] a,
                                       input logic [2:0] sz, input logic [31:0] d);
      int w;
      logic en;
      w = int'(a[9:2]);
      for (int b = 0; b < 4; b++) begin
         en = (sz == 3'd2) || ((sz == 3'd1) && ((b / 2) == int'(a[1]))) ||
              ((sz == 3'd0) && (b == int'(a[1:0])));
         if (en) mem_m[k][w][8*b +: 8] = d[8*b +: 8];
      end
   endfunction

   task automatic drive_addr(input int k, input xfer_t x);
      hsel_a[k]   = x.sel;
      haddr_a[k]  = x.addr;
      hwrite_a[k] = x.write;
      hsize_a[k]  = x.size;
      htrans_a[k] = x.trans;
      hburst_a[k] = 3'($urandom_range(0, 7));
   endtask

   // Pipelined master: plays seq_q into instance k and checks each data
   // phase (wait count, hresp in every cycle, hrdata in every cycle).
   task automatic applyStimulus(input int k);
      xfer_t ap;
      xfer_t dp;
      logic  dp_valid;
      logic  dp_err;
      int    waits;
      int    cycles;
      int    exp_waits;
      logic  rdy;
      logic  resp;
      logic [31:0] rd;

      @(posedge hclk);
      #1;
      dp       = idle_x();
      dp_valid = 1'b0;
      waits    = 0;
      cycles   = 0;
      if (seq_q.size() > 0) ap = seq_q.pop_front();
      else begin ap = idle_x(); ap.filler = 1'b1; end
      drive_addr(k, ap);
      forever begin
         @(negedge hclk);
         rdy    = hreadyout_a[k];
         resp   = hresp_a[k];
         rd     = hrdata_a[k];
         dp_err = dp_valid && model_err(dp.addr, dp.size);
         cycles++;
         if (cycles > CYCLE_LIMIT) begin
            checkOutput(k, "cycle_budget", 32'(cycles), 32'(CYCLE_LIMIT));
            break;
         end
         if (!rdy) begin
            waits++;
            checkOutput(k, "hresp_wait", 32'(resp), 32'(dp_err));
            checkOutput(k, "hrdata_hold", rd, last_rd[k]);
         end else begin
            if (dp_valid && !dp_err && !dp.write) last_rd[k] = mem_m[k][dp.addr[9:2]];
            exp_waits = !dp_valid ? 0 : (dp_err ? 1 : WS[k]);
            checkOutput(k, "hrdata", rd, last_rd[k]);
            checkOutput(k, "hresp", 32'(resp), 32'(dp_err));
            checkOutput(k, "wait_cycles", 32'(waits), 32'(exp_waits));
            if (dp_valid && !dp_err && dp.write) model_write(k, dp.addr, dp.size, dp.wdata);
            if (dp.filler) break;
            dp       = ap;
            dp_valid = ap.sel && ap.trans[1];
            waits    = 0;
            @(posedge hclk);
            #1;
            hwdata_a[k] = dp.write ? dp.wdata : $urandom;
            if (seq_q.size() > 0) ap = seq_q.pop_front();
            else begin ap = idle_x(); ap.filler = 1'b1; end
            drive_addr(k, ap);
         end
      end
      @(posedge hclk);
      #1;
      drive_addr(k, idle_x());
      seq_q.delete();
   endtask

   task automatic push_random(input int n);
      xfer_t x;
      int    mode;
      int    tmode;
      for (int i = 0; i < n; i++) begin
         x    = mk(1'($urandom_range(0, 1)), 32'd0, 3'($urandom_range(0, 2)), $urandom);
         mode = $urandom_range(0, 9);
         x.addr = 32'($urandom_range(0, 15)) << 2;
         if (x.size == 3'd0) x.addr[1:0] = 2'($urandom_range(0, 3));
         if (x.size == 3'd1) x.addr[1]   = 1'($urandom_range(0, 1));
         if (mode == 0) x.addr = 32'h400 + (32'($urandom_range(0, 255)) << 2);
         if (mode == 1) x.size = 3'($urandom_range(3, 7));
         if (mode == 2) x.addr[1:0] = 2'($urandom_range(0, 3));
         tmode = $urandom_range(0, 9);
         if (tmode == 0) x.trans = 2'b00;
         else if (tmode == 1) x.trans = 2'b01;
         else if (tmode == 2) x.sel = 1'b0;
         else x.trans = 2'($urandom_range(2, 3));
         seq_q.push_back(x);
      end
   endtask

   initial begin
      xfer_t x;
      tests_run    = 0;
      tests_failed = 0;
      hresetn      = 1'b0;
      for (int k = 0; k < NI; k++) begin
         drive_addr(k, idle_x());
         hwdata_a[k] = 32'd0;
         last_rd[k]  = 32'd0;
      end

      // Reset state
      #2;
      for (int k = 0; k < NI; k++) begin
         checkOutput(k, "rst_hreadyout", 32'(hreadyout_a[k]), 32'd1);
         checkOutput(k, "rst_hresp", 32'(hresp_a[k]), 32'd0);
         checkOutput(k, "rst_hrdata", hrdata_a[k], 32'd0);
      end
      repeat (3) @(negedge hclk);
      hresetn = 1'b1;

      for (int k = 0; k < NI; k++) begin
         // Fill the working region so every later read has a known value
         for (int w = 0; w < 16; w++) seq_q.push_back(mk(1'b1, 32'(w * 4), 3'd2, $urandom));
         applyStimulus(k);

         // Word write then read
         seq_q.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF));
         seq_q.push_back(mk(1'b0, 32'h10, 3'd2, 32'd0));
         applyStimulus(k);
         checkOutput(k, "word_rd", hrdata_a[k], 32'hDEADBEEF);

         // Byte and halfword lanes
         seq_q.push_back(mk(1'b1, 32'h20, 3'd2, 32'h11223344));
         seq_q.push_back(mk(1'b1, 32'h22, 3'd0, 32'h00AA0000));
         seq_q.push_back(mk(1'b1, 32'h20, 3'd1, 32'h00005566));
         seq_q.push_back(mk(1'b0, 32'h20, 3'd2, 32'd0));
         applyStimulus(k);
         checkOutput(k, "lane_merge", hrdata_a[k], 32'h11AA5566);

         // Back-to-back reads
         seq_q.push_back(mk(1'b0, 32'h10, 3'd2, 32'd0));
         seq_q.push_back(mk(1'b0, 32'h14, 3'd2, 32'd0));
         applyStimulus(k);

         // Error responses, then OKAY traffic straight after
         seq_q.push_back(mk(1'b1, 32'h400, 3'd2, 32'hCAFEF00D));
         seq_q.push_back(mk(1'b1, 32'h02, 3'd2, 32'hBAD0BAD0));
         seq_q.push_back(mk(1'b0, 32'h00, 3'd3, 32'd0));
         seq_q.push_back(mk(1'b1, 32'h21, 3'd1, 32'hFFFFFFFF));
         x = mk(1'b1, 32'h3FC, 3'd2, 32'h0BADF00D); x.trans = 2'b11; seq_q.push_back(x);
         x = mk(1'b1, 32'h400, 3'd2, 32'h0BADF00D); x.trans = 2'b11; seq_q.push_back(x);
         seq_q.push_back(mk(1'b0, 32'h00, 3'd2, 32'd0));
         seq_q.push_back(mk(1'b0, 32'h20, 3'd2, 32'd0));
         applyStimulus(k);
         checkOutput(k, "err_no_write", hrdata_a[k], 32'h11AA5566);

         // Read right behind a write to the same word
         seq_q.push_back(mk(1'b1, 32'h30, 3'd2, 32'h12345678));
         seq_q.push_back(mk(1'b0, 32'h30, 3'd2, 32'd0));
         applyStimulus(k);
         checkOutput(k, "raw_bypass", hrdata_a[k], 32'h12345678);

         // IDLE, BUSY and deselected beats must not touch memory
         x = mk(1'b1, 32'h30, 3'd2, 32'hFFFFFFFF); x.trans = 2'b00; seq_q.push_back(x);
         x = mk(1'b1, 32'h30, 3'd2, 32'hFFFFFFFF); x.trans = 2'b01; seq_q.push_back(x);
         x = mk(1'b1, 32'h30, 3'd2, 32'hFFFFFFFF); x.sel = 1'b0;   seq_q.push_back(x);
         seq_q.push_back(mk(1'b0, 32'h30, 3'd2, 32'd0));
         applyStimulus(k);
         checkOutput(k, "idle_no_write", hrdata_a[k], 32'h12345678);

         // Randomised traffic
         push_random(60);
         applyStimulus(k);
      end

      // Reset while a write sits in WAIT (WAIT_STATES = 3 instance)
      @(posedge hclk);
      #1;
      drive_addr(2, mk(1'b1, 32'h3C, 3'd2, 32'd0));
      @(posedge hclk);
      #1;
      hwdata_a[2] = ~mem_m[2][15];
      drive_addr(2, idle_x());
      @(negedge hclk);
      checkOutput(2, "in_wait", 32'(hreadyout_a[2]), 32'd0);
      hresetn = 1'b0;
      #1;
      checkOutput(2, "abort_hreadyout", 32'(hreadyout_a[2]), 32'd1);
      checkOutput(2, "abort_hresp", 32'(hresp_a[2]), 32'd0);
      checkOutput(2, "abort_hrdata", hrdata_a[2], 32'd0);
      repeat (2) @(negedge hclk);
      hresetn = 1'b1;
      for (int k = 0; k < NI; k++) last_rd[k] = 32'd0;
      applyStimulus(0);
      applyStimulus(1);
      seq_q.push_back(mk(1'b0, 32'h3C, 3'd2, 32'd0));
      applyStimulus(2);
      checkOutput(2, "abort_kept_old", hrdata_a[2], mem_m[2][15]);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AHB-Lite slave (responder) holding a word-addressed memory. It completes transfers issued by the team's ahb_master.
- Wait-state insertion is configurable.
- Byte-lane writes follow HSIZE.
- Out-of-range, unaligned or oversize accesses get the standard two-cycle ERROR response.
- Sits behind the bus decoder. The decoder drives hsel and the mux returns hreadyout/hresp/hrdata to the master.

Parameters:
DEPTH, 256, number of 32-bit words; valid byte addresses 0 .. DEPTH*4-1.
WAIT_STATES, 0, hreadyout-low cycles inserted before each OKAY data phase (0..15).

Ports:
hclk  in  1  bus clock, rising-edge.
hresetn  in  1  asynchronous active-low reset.
hsel  in  1  slave select from decoder.
haddr  in  32  byte address (address phase).
hwrite  in  1  1=write, 0=read.
hsize  in  3  0=byte, 1=halfword, 2=word.
hburst  in  3  accepted and ignored; every beat is handled independently.
htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
hready  in  1  bus-level ready (previous data phase complete).
hwdata  in  32  write data (data phase).
hreadyout  out  1  slave ready for current data phase.
hresp  out  1  0=OKAY, 1=ERROR.
hrdata  out  32  read data, valid when hreadyout=1 in a read data phase.

Behaviour:
- Reset (async assert, sync release): state=IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter=0. Memory contents are not reset and are retained. Reset mid-wait or mid-error aborts the transfer; no write commits.
- Transfer accepted at a rising edge when hsel=1, hready=1 and htrans[1]=1 (NONSEQ/SEQ).
  - On acceptance, register haddr, hwrite and hsize.
  - IDLE/BUSY, or hsel=0: no access; the next data phase is zero-wait OKAY.
- Error check at acceptance. The transfer is an error if any of:
  - haddr >= DEPTH*4;
  - hsize > 2;
  - hsize=1 and haddr[0]=1;
  - hsize=2 and haddr[1:0]!=0.
- States:
  - IDLE: hreadyout=1, hresp=0.
    - Accept OK: go to WAIT if WAIT_STATES>0, else ACCESS.
    - Accept error: go to ERR1.
  - WAIT: hreadyout=0, hresp=0. Counter loads WAIT_STATES-1 and decrements; at 0 go to ACCESS.
  - ACCESS: hreadyout=1, hresp=0.
    - Write: commit hwdata to the enabled byte lanes at the closing edge.
    - Read: hrdata holds the word fetched at entry.
    - Back-to-back: a new accept at the same edge goes to WAIT, ACCESS or ERR1; otherwise go to IDLE.
  - ERR1: hreadyout=0, hresp=1. Always go to ERR2.
  - ERR2: hreadyout=1, hresp=1. A new accept at this edge is processed as from IDLE; otherwise go to IDLE. No memory write occurs for an errored transfer.
- Byte lanes are little-endian: lane k = bits 8k+7:8k.
  - byte: lane haddr[1:0].
  - halfword: lanes {haddr[1],0} and {haddr[1],1}.
  - word: all lanes.
  - Unenabled lanes are unchanged.
- Reads always return the full 32-bit word; the master extracts lanes.
- hrdata is updated only on entry to a read ACCESS. It holds its value otherwise, including during writes and errors.
- Read latency = 1 + WAIT_STATES cycles from the address-phase edge.
- Read-after-write hazard: a read accepted at the same edge a write commits to the same word must return the merged post-write word (bypass). No stale data.
- hburst is not checked. SEQ beats follow the same rules as NONSEQ, including error on crossing the DEPTH boundary.
- hsel deasserted during a data phase does not abort it; the data phase completes normally.

Test Plan:
- Reset: hresetn=0 with bus idle -> hreadyout=1, hresp=0, hrdata=0. Assert reset while in WAIT (WAIT_STATES=3) -> immediate IDLE outputs; later read of that address shows the old content.
- Word write/read, WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 -> hreadyout never low; hrdata=0xDEADBEEF one cycle after the read address phase.
- Byte/halfword lanes: word 0x20=0x11223344; byte write 0xAA at 0x22; halfword write 0x5566 at 0x20 -> read 0x20 returns 0x11AA5566.
- Wait states, WAIT_STATES=2: read 0x10 -> hreadyout low for exactly 2 cycles, then 1 with valid data. Back-to-back NONSEQ reads of 0x10 and 0x14 -> each incurs 2 wait cycles, no bubble beyond that.
- Errors, DEPTH=256:
  - write to 0x400 -> ERR1 (hreadyout=0, hresp=1), then ERR2 (1,1), memory unchanged.
  - word access at 0x02 -> ERROR.
  - hsize=3 -> ERROR.
  - Transfer following the error gets OKAY.
- Pipelined RAW: write 0x12345678 to 0x30 immediately followed by read 0x30 -> read returns 0x12345678. IDLE/BUSY htrans with hsel=1 -> zero-wait OKAY, memory untouched.
